// File: rtl/gf180mcu_osu_sc_drv_pkg.sv
// Shared types and constants for the gf180mcu OSU staggered driver cells.
package gf180mcu_osu_sc_drv_pkg;

  typedef enum logic {
    IDLE,
    RAMP
  } drv_state_e;

  localparam logic PARK_LEVEL = 1'b1;

  localparam int unsigned SEGS_MAX = 32;
  localparam int unsigned STEP_MAX = 15;

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__sync2.sv
// Two-flop synchronizer for bringing an asynchronous level into the CLK domain.
module gf180mcu_osu_sc_gp12t3v3__sync2 (
  input  logic CLK,
  input  logic RN,
  input  logic D,
  output logic Q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= D;
      sync_q <= meta_q;
    end
  end

  assign Q = sync_q;

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__drv_stagger.sv
// Staggered pre-driver: ramps SEGS segment outputs toward ~A one at a time, STEP cycles apart.
// Define GF180MCU_OSU_SC_DRV_STAGGER_SYNC_EN to put a 2-flop synchronizer in front of a_q.
module gf180mcu_osu_sc_gp12t3v3__drv_stagger
  import gf180mcu_osu_sc_drv_pkg::*;
#(
  parameter int unsigned SEGS = 8,
  parameter int unsigned STEP = 2
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            A,
  input  logic            EN,
  output logic [SEGS-1:0] Y,
  output logic            BUSY
);

  localparam int unsigned IDX_W = $clog2(SEGS) + 1;
  localparam int unsigned CNT_W = $clog2(STEP) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEGS - 1);
  localparam logic [CNT_W-1:0] STEP_M1  = CNT_W'(STEP - 1);

  if ((SEGS < 1) || (SEGS > SEGS_MAX) || (STEP < 1) || (STEP > STEP_MAX)) begin : g_param_err
    $error("drv_stagger: SEGS must be 1..%0d and STEP 1..%0d", SEGS_MAX, STEP_MAX);
  end

  logic a_in;

`ifdef GF180MCU_OSU_SC_DRV_STAGGER_SYNC_EN
  gf180mcu_osu_sc_gp12t3v3__sync2 u_sync2 (
    .CLK (CLK),
    .RN  (RN),
    .D   (A),
    .Q   (a_in)
  );
`else
  assign a_in = A;
`endif

  logic             a_q;
  drv_state_e       state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [SEGS-1:0]  y_q, y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      a_q     <= 1'b0;
      state_q <= IDLE;
      tgt_q   <= PARK_LEVEL;
      y_q     <= {SEGS{PARK_LEVEL}};
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_in;
      state_q <= state_d;
      tgt_q   <= tgt_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: park on EN low, then (re)start on a new target, then step the ramp.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    y_d     = y_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!EN) begin
      state_d = IDLE;
      tgt_d   = PARK_LEVEL;
      y_d     = {SEGS{PARK_LEVEL}};
      idx_d   = '0;
      cnt_d   = '0;
    end else if (~a_q != tgt_q) begin
      tgt_d   = ~a_q;
      y_d[0]  = ~a_q;
      idx_d   = IDX_W'(1);
      cnt_d   = STEP_M1;
      state_d = (SEGS == 1) ? IDLE : RAMP;
    end else if (state_q == RAMP) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        for (int i = 1; i < SEGS; i++) begin
          if (idx_q == IDX_W'(i)) y_d[i] = tgt_q;
        end
        cnt_d = STEP_M1;
        // idx parks on the last segment rather than running past it.
        if (idx_q == LAST_IDX) state_d = IDLE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    Y    = y_q;
    BUSY = (state_q == RAMP);
  end

endmodule
